// File: rtl/sam_pkg.sv
// sam_pkg -- shared types and constants for the SAM Coupe memory arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, ISSUE, WAIT, DONE)
//   arb_src_t    : requester identity (loader, FDC buffer, CPU)
//   FDC_BASE_DEF : default upper address bits of the FDC buffer window
//   src_onehot() : maps a requester to its ack bit {cpu, fdc, ldr}
package sam_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      SRC_LDR = 2'd0,
      SRC_FDC = 2'd1,
      SRC_CPU = 2'd2
   } arb_src_t;

   localparam logic [4:0] FDC_BASE_DEF = 5'h02;

   // Ack vector layout is {cpu, fdc, ldr}
   function automatic logic [2:0] src_onehot(input arb_src_t src);
      logic [2:0] vec;
      case (src)
         SRC_LDR: vec = 3'b001;
         SRC_FDC: vec = 3'b010;
         SRC_CPU: vec = 3'b100;
         default: vec = 3'b000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick -- combinational winner selection for the memory arbiter.
//   ldr_req  : loader request, always wins
//   fdc_req  : FDC buffer request
//   cpu_req  : CPU request
//   last_fdc : 1 when the most recent FDC/CPU grant went to the FDC
//   src      : selected requester (only meaningful when any request is high)
module arb_pick
   import sam_pkg::*;
(
   input  logic     ldr_req,
   input  logic     fdc_req,
   input  logic     cpu_req,
   input  logic     last_fdc,
   output arb_src_t src
);

   // Loader first; FDC and CPU alternate when both are asking
   always_comb begin
      src = SRC_CPU;
      if (ldr_req) begin
         src = SRC_LDR;
      end else if (fdc_req && cpu_req) begin
         src = last_fdc ? SRC_CPU : SRC_FDC;
      end else if (fdc_req) begin
         src = SRC_FDC;
      end else begin
         src = SRC_CPU;
      end
   end

endmodule

// File: rtl/sam_mem_arbiter.sv
// sam_mem_arbiter -- single-port RAM arbiter for the SAM Coupe core.
// Shares the SDRAM-backed byte port between the ioctl loader (writes), the
// WD1793 disk-buffer reader (reads) and the Z80 memory cycle. Each access runs
// IDLE (pick + latch) -> ISSUE (strobe) -> WAIT (mem_ready or timeout) -> DONE (ack).
// Ports:
//   clk_sys, reset                    : clock, synchronous active-high reset
//   ldr_req/ldr_addr/ldr_din, ldr_ack : loader write requester
//   fdc_req/fdc_addr, fdc_ack         : FDC buffer reader, rd_data valid with ack
//   cpu_req/we/wp/addr/din, cpu_ack   : Z80 requester; cpu_wp suppresses writes
//   cpu_wait                          : stalls the CPU until its ack
//   rd_data                           : last read data (8'hFF after reset/timeout)
//   mem_addr/mem_din/mem_we/mem_rd    : RAM command port (one-cycle strobes)
//   mem_dout/mem_ready                : RAM read data and completion pulse
//   err                               : sticky timeout flag
module sam_mem_arbiter
   import sam_pkg::*;
#(
   parameter int         ADDR_W   = 25,
   parameter logic [4:0] FDC_BASE = FDC_BASE_DEF,
   parameter int         TIMEOUT  = 31
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [7:0]        ldr_din,
   output logic              ldr_ack,
   input  logic              fdc_req,
   input  logic [19:0]       fdc_addr,
   output logic              fdc_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_wp,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic [7:0]        rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [7:0]        mem_dout,
   input  logic              mem_ready,
   output logic              err
);

   localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   arb_state_t        state_q, state_d;
   arb_src_t          src_q, src_d;
   arb_src_t          pick_src_s;
   logic              any_req_s;
   logic              we_q, we_d;
   logic              skip_q, skip_d;          // write-protected CPU write: no strobe
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_fdc_q, last_fdc_d;
   logic [2:0]        ack_q, ack_d;            // {cpu, fdc, ldr}
   logic [7:0]        rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_rd_q, mem_rd_d;
   logic              err_q, err_d;

   assign any_req_s = ldr_req | fdc_req | cpu_req;

   arb_pick u_pick (
      .ldr_req  (ldr_req),
      .fdc_req  (fdc_req),
      .cpu_req  (cpu_req),
      .last_fdc (last_fdc_q),
      .src      (pick_src_s)
   );

   // Next-state and datapath: strobes are set in IDLE so they are visible in ISSUE,
   // acks are set on the transition into DONE so they are visible during DONE
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      we_d       = we_q;
      skip_d     = skip_q;
      cnt_d      = cnt_q;
      last_fdc_d = last_fdc_q;
      ack_d      = 3'b000;
      rd_data_d  = rd_data_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      mem_rd_d   = 1'b0;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               src_d   = pick_src_s;
               state_d = ISSUE;
               case (pick_src_s)
                  SRC_LDR: begin
                     we_d       = 1'b1;
                     skip_d     = 1'b0;
                     mem_addr_d = ldr_addr;
                     mem_din_d  = ldr_din;
                  end
                  SRC_FDC: begin
                     we_d       = 1'b0;
                     skip_d     = 1'b0;
                     mem_addr_d = ADDR_W'({FDC_BASE, fdc_addr});
                     mem_din_d  = 8'h00;
                     last_fdc_d = 1'b1;
                  end
                  default: begin
                     we_d       = cpu_we;
                     skip_d     = cpu_we & cpu_wp;
                     mem_addr_d = cpu_addr;
                     mem_din_d  = cpu_din;
                     last_fdc_d = 1'b0;
                  end
               endcase
               mem_we_d = we_d & ~skip_d;
               mem_rd_d = ~we_d;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (skip_q) begin
               state_d = DONE;
               ack_d   = src_onehot(src_q);
            end else begin
               state_d = WAIT;
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         WAIT: begin
            if (mem_ready) begin
               if (!we_q) begin
                  rd_data_d = mem_dout;
               end else begin
                  rd_data_d = rd_data_q;
               end
               state_d = DONE;
               ack_d   = src_onehot(src_q);
            end else if (cnt_q == CNT_LIMIT) begin
               err_d     = 1'b1;
               rd_data_d = 8'hFF;
               state_d   = DONE;
               ack_d     = src_onehot(src_q);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any access in flight without an ack
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= IDLE;
         src_q      <= SRC_LDR;
         we_q       <= 1'b0;
         skip_q     <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         last_fdc_q <= 1'b0;
         ack_q      <= 3'b000;
         rd_data_q  <= 8'hFF;
         mem_addr_q <= {ADDR_W{1'b0}};
         mem_din_q  <= 8'h00;
         mem_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         we_q       <= we_d;
         skip_q     <= skip_d;
         cnt_q      <= cnt_d;
         last_fdc_q <= last_fdc_d;
         ack_q      <= ack_d;
         rd_data_q  <= rd_data_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         mem_rd_q   <= mem_rd_d;
         err_q      <= err_d;
      end
   end

   assign ldr_ack  = ack_q[0];
   assign fdc_ack  = ack_q[1];
   assign cpu_ack  = ack_q[2];
   // Drops in the ack cycle so the CPU clock enable resumes immediately
   assign cpu_wait = cpu_req & ~ack_q[2];
   assign rd_data  = rd_data_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;
   assign mem_rd   = mem_rd_q;
   assign err      = err_q;

endmodule

// File: doc/sam_mem_arbiter.md
# sam_mem_arbiter

Single-port RAM arbiter for the SAM Coupé core. It shares the SDRAM-backed `sram` port between three requesters: the ioctl loader (ROM/disk image download), the WD1793 disk-buffer reader and the Z80 memory cycle. It sequences each access as request → issue → wait for `mem_ready` → acknowledge. It also drives `cpu_wait`, which feeds the CPU clock-enable gating alongside the video contention waits.

## Interface
Parameters:
- `ADDR_W`, 25: RAM byte-address width.
- `FDC_BASE`, 5'h02: fixed upper bits prepended to the 20-bit FDC buffer address.
- `TIMEOUT`, 31: maximum cycles spent in WAIT before the access is aborted.

Ports (`clk_sys` with synchronous, active-high `reset`, as already decided):
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ldr_req` in 1: loader request (level).
- `ldr_addr` in ADDR_W: loader write address.
- `ldr_din` in 8: loader write data.
- `ldr_ack` out 1: one-cycle pulse when the write completes.
- `fdc_req` in 1: FDC buffer read request (level).
- `fdc_addr` in 20: FDC buffer offset.
- `fdc_ack` out 1: one-cycle pulse; `rd_data` is valid in the same cycle.
- `cpu_req` in 1: CPU memory cycle request (level).
- `cpu_we` in 1: 1 = write.
- `cpu_wp` in 1: write-protect/ROM/ext-RAM (write is suppressed).
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_ack` out 1: one-cycle pulse when the access completes.
- `cpu_wait` out 1: high while a CPU request is pending and not yet acked.
- `rd_data` out 8: last read data, held until the next read completes.
- `mem_addr` out ADDR_W: RAM address.
- `mem_din` out 8: RAM write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_dout` in 8: RAM read data.
- `mem_ready` in 1: one-cycle completion pulse from the RAM.
- `err` out 1: sticky flag set by a timeout; cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: select the winner from the requests sampled this cycle and latch its address, data and direction. Go to ISSUE the next cycle.
- Priority:
  - `ldr_req` is absolute.
  - Between FDC and CPU, alternation: a 1-bit `last_fdc` flag is set on an FDC grant and cleared on a CPU grant. When both request, the one not served last wins.
- ISSUE: drive `mem_addr`/`mem_din`, pulse `mem_rd` (read) or `mem_we` (write) for one cycle, then go to WAIT.
- FDC address is `{FDC_BASE, fdc_addr}`. FDC accesses are always reads; loader accesses are always writes.
- CPU write with `cpu_wp=1`: no strobe is issued. Go from ISSUE directly to DONE, so the access is acked without touching memory.
- WAIT: on `mem_ready`, capture `mem_dout` into `rd_data` if the access is a read, then go to DONE.
  - The timeout counter increments each WAIT cycle.
  - When the counter reaches TIMEOUT: set `err`, set `rd_data`=8'hFF and go to DONE.
- DONE: pulse the winner's ack for one cycle, then return to IDLE. The next grant is decided in that IDLE cycle.
- Requesters must drop or change their request after an ack. A request still high in IDLE is treated as a new access.
- A request deasserted mid-access does not abort it; the access completes and the ack is still pulsed.
- `cpu_wait` = `cpu_req` & ~`cpu_ack` (combinational from the registered ack).
- `mem_ready` is ignored outside WAIT.
- Reset values:
  - state IDLE.
  - All acks, `mem_we`, `mem_rd` and `err` = 0.
  - `rd_data` = 8'hFF.
  - `mem_addr`/`mem_din` = 0.
  - `last_fdc` = 0.
  - Timeout counter = 0.
- Reset mid-access: the access is dropped with no ack and the FSM returns to IDLE on the next edge.

## Timing
- Minimum latency, request seen in IDLE at cycle 0: ISSUE at cycle 1 (strobe), WAIT from cycle 2.
- With `mem_ready` at cycle 2, DONE/ack is at cycle 3. Back-to-back accesses therefore take 4 cycles each.
- Write-protected CPU write: ack at cycle 2.
- Timeout: ack at cycle 2+TIMEOUT+1 at most.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits and saturates. It is cleared on entry to WAIT.

## Structure
- `sam_pkg` holds:
  - The state enum `arb_state_t` (IDLE, ISSUE, WAIT, DONE).
  - The requester-ID enum `arb_src_t` (SRC_LDR, SRC_FDC, SRC_CPU).
  - The constant `FDC_BASE_DEF` = 5'h02.
- A sub-module `arb_pick` holds the combinational priority and alternation selection, with inputs the three requests and `last_fdc`, and output `arb_src_t`. The FSM and datapath stay in the top module.

## Test plan
- Reset, then single CPU read at 25'h004000; the model returns 8'hA5 with `mem_ready` 1 cycle after the strobe → `mem_rd` at cycle 1, `cpu_ack` with `rd_data`=8'hA5 at cycle 3, `cpu_wait` low after the ack.
- `fdc_req` and `cpu_req` held together for 4 accesses → grant order FDC, CPU, FDC, CPU; the FDC `mem_addr` equals 25'h200000+`fdc_addr`.
- `ldr_req` asserted while a CPU access is in WAIT → the CPU access completes first; the loader then wins over pending FDC/CPU requests on every grant until `ldr_req` drops.
- CPU write to 25'h000010 with `cpu_wp`=1 → no `mem_we` pulse, `cpu_ack` at cycle 2, memory model unchanged.
- Model never returns `mem_ready` → `err` sets after TIMEOUT WAIT cycles, ack is pulsed with `rd_data`=8'hFF, and the next request is serviced normally.
- Reset asserted during WAIT → no ack pulse, all outputs return to their reset values one cycle later, and a stale `mem_ready` after reset is ignored.
